// File: rtl/fourphase_pkg.sv
// Shared definitions for the four-phase bundled-data link.
// Contents:
//   fp_state_e             - transmitter handshake FSM states
//   FP_SYNC_STAGES_DEFAULT - default ack/req synchronizer depth; the
//                            receiving-side block uses the same default
package fourphase_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } fp_state_e;

    localparam int FP_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sync_flop.sv
// N-stage flop synchronizer for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears every stage to 0
//   d_i - asynchronous input
//   q_o - synchronized output (N clk edges of latency)
module sync_flop #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/fourphase_tx.sv
// Clocked four-phase (return-to-zero) bundled-data transmitter.
// Words enter through a small FIFO and are driven onto data_out, held for
// SETUP_CYCLES, then handed to the asynchronous pipeline with req/ack.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   in_data      - word to send
//   in_valid     - in_data is valid
//   in_ready     - FIFO has room
//   data_out     - registered bundled data toward the async pipeline
//   req          - registered four-phase request
//   ack          - four-phase acknowledge, asynchronous to clk
//   busy         - handshake in progress or FIFO not empty
//   level        - FIFO occupancy
//   dbg_state_o  - current handshake FSM state
//
// Input handshake: a word is accepted on every rising clk edge where
// in_valid and in_ready are both high; in_ready depends only on registered
// occupancy, so it never combinationally depends on in_valid.
module fourphase_tx
    import fourphase_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int SYNC_STAGES  = FP_SYNC_STAGES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   req,
    input  logic                   ack,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output fp_state_e              dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_INIT = (SETUP_CYCLES > 0) ? CW'(SETUP_CYCLES - 1) : '0;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push, pop;
    logic             ack_s;

    fp_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;

    sync_flop #(.N(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ack),
        .q_o (ack_s)
    );

    // ---------------- FIFO ----------------
    assign in_ready = (level_q != LVL_FULL);
    assign push     = in_valid & in_ready;

    // Storage is not reset: only entries below level_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- Handshake FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    // A pop only ever happens with req low and ack_s low, so data_out never
    // moves while the responder may be sampling it. Pops read level_q, which
    // excludes a word being pushed on the same edge (no bypass).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // A high ack_s here is a leftover from an earlier or aborted
                // handshake; wait for it to return to zero first.
                if (level_q != '0 && !ack_s) begin
                    pop    = 1'b1;
                    data_d = mem_q[rd_ptr_q];
                    if (SETUP_CYCLES == 0) begin
                        req_d   = 1'b1;
                        state_d = REQ_HI;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    if (level_q != '0) begin
                        pop    = 1'b1;
                        data_d = mem_q[rd_ptr_q];
                        if (SETUP_CYCLES == 0) begin
                            req_d   = 1'b1;
                            state_d = REQ_HI;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = SETUP;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out    = data_q;
    assign req         = req_q;
    assign level       = level_q;
    assign busy        = (state_q != IDLE) || (level_q != '0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fourphase_tx.sv
// Bench for fourphase_tx: DUT A uses default parameters, DUT B uses
// SETUP_CYCLES=0. A cycle-stepped responder model answers DUT A's
// handshakes and checks each word against the expected-word queue.
module tb_fourphase_tx;
    import fourphase_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SS = 2;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;

    logic [W-1:0]  in_data_a, data_out_a;
    logic          in_valid_a, in_ready_a, req_a, ack_a, busy_a;
    logic [LW-1:0] level_a;
    fp_state_e     dbg_state_a;

    logic [W-1:0]  in_data_b, data_out_b;
    logic          in_valid_b, in_ready_b, req_b, ack_b, busy_b;
    logic [LW-1:0] level_b;
    fp_state_e     dbg_state_b;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_word;
    logic         resp_en;
    logic         in_hs;
    int           hi_cnt, lo_cnt, hs_done;

    always #5 clk = ~clk;

    fourphase_tx #(.WIDTH(W), .DEPTH(D), .SETUP_CYCLES(2), .SYNC_STAGES(SS)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .data_out(data_out_a), .req(req_a), .ack(ack_a),
        .busy(busy_a), .level(level_a), .dbg_state_o(dbg_state_a)
    );

    fourphase_tx #(.WIDTH(W), .DEPTH(D), .SETUP_CYCLES(0), .SYNC_STAGES(SS)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .data_out(data_out_b), .req(req_b), .ack(ack_b),
        .busy(busy_b), .level(level_b), .dbg_state_o(dbg_state_b)
    );

    // Responder for DUT A: raise ack on the 3rd sample of req high, drop it
    // on the 3rd sample of req low. Checks the word at req rise, ack rise and
    // req fall.
    task automatic resp_step();
        if (req_a && !ack_a) begin
            if (!in_hs) begin
                in_hs  = 1'b1;
                hi_cnt = 0;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL resp_unexpected_word: data_out=%h with no word expected", data_out_a);
                end else begin
                    cur_word = exp_q.pop_front();
                    if (data_out_a !== cur_word)
                        $display("FAIL resp_word_at_req_rise: data_out=%h expected=%h", data_out_a, cur_word);
                    else passed++;
                end
            end
            hi_cnt++;
            if (hi_cnt == 3) begin
                total++;
                if (data_out_a !== cur_word)
                    $display("FAIL resp_word_at_ack_rise: data_out=%h expected=%h", data_out_a, cur_word);
                else passed++;
                ack_a = 1'b1;
            end
        end else if (!req_a && ack_a) begin
            lo_cnt++;
            if (lo_cnt == 1) begin
                total++;
                if (data_out_a !== cur_word)
                    $display("FAIL resp_word_at_req_fall: data_out=%h expected=%h", data_out_a, cur_word);
                else passed++;
            end
            if (lo_cnt == 3) begin
                ack_a   = 1'b0;
                lo_cnt  = 0;
                in_hs   = 1'b0;
                hs_done++;
            end
        end
    endtask

    task automatic resp_start();
        in_hs   = 1'b0;
        hi_cnt  = 0;
        lo_cnt  = 0;
        hs_done = 0;
        resp_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (resp_en) resp_step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp_en = 1'b0;
        repeat (3) tick();
        total++;
        if ({req_a, level_a, in_ready_a, data_out_a} !== {1'b0, LW'(0), 1'b1, 8'h00})
            $display("FAIL reset_held: req=%b level=%0d in_ready=%b data_out=%h expected 0/0/1/00",
                     req_a, level_a, in_ready_a, data_out_a);
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (req_a !== 1'b0 || data_out_a !== 8'h00 || level_a !== LW'(0) ||
                in_ready_a !== 1'b1 || busy_a !== 1'b0)
                $display("FAIL reset_idle cycle %0d: req=%b data_out=%h level=%0d in_ready=%b busy=%b expected 0/00/0/1/0",
                         i, req_a, data_out_a, level_a, in_ready_a, busy_a);
            else passed++;
        end
    endtask

    task automatic test_single();
        int k;
        exp_q.delete();
        resp_start();
        in_data_a  = 8'hA5;
        in_valid_a = 1'b1;
        exp_q.push_back(8'hA5);
        tick();                               // edge N: push
        in_valid_a = 1'b0;
        total++;
        if (level_a !== LW'(1) || req_a !== 1'b0)
            $display("FAIL single_after_push: level=%0d req=%b expected 1/0", level_a, req_a);
        else passed++;
        tick();                               // edge N+1: pop into data_out
        total++;
        if (data_out_a !== 8'hA5 || req_a !== 1'b0)
            $display("FAIL single_data_load: data_out=%h req=%b expected a5/0", data_out_a, req_a);
        else passed++;
        tick();                               // edge N+2
        total++;
        if (req_a !== 1'b0) $display("FAIL single_req_early: req=%b expected 0", req_a);
        else passed++;
        tick();                               // edge N+3: req rises
        total++;
        if (req_a !== 1'b1) $display("FAIL single_req_rise: req=%b expected 1", req_a);
        else passed++;
        k = 0;
        while (!ack_a && k < 20) begin tick(); k++; end
        // ack is set just after an edge: two sync edges, then the FSM edge.
        k = 0;
        while (req_a && k < 10) begin tick(); k++; end
        total++;
        if (k !== SS + 1) $display("FAIL single_req_fall_delay: cycles=%0d expected %0d", k, SS + 1);
        else passed++;
        k = 0;
        while ((busy_a || ack_a) && k < 40) begin tick(); k++; end
        total++;
        if (busy_a !== 1'b0 || dbg_state_a !== IDLE || req_a !== 1'b0 || hs_done !== 1 || exp_q.size() != 0)
            $display("FAIL single_return_idle: busy=%b state=%0d req=%b handshakes=%0d pending=%0d expected 0/0/0/1/0",
                     busy_a, dbg_state_a, req_a, hs_done, exp_q.size());
        else passed++;
        resp_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  k;
        logic stalled;
        exp_q.delete();
        resp_en = 1'b0;
        ack_a   = 1'b0;
        stalled = 1'b0;
        for (int w = 1; w <= 6; w++) begin
            in_data_a  = 8'(w);
            in_valid_a = 1'b1;
            k = 0;
            while (!in_ready_a && k < 300) begin
                if (k == 4 && !resp_en) begin
                    stalled = 1'b1;
                    total++;
                    if (level_a !== LW'(D) || req_a !== 1'b1 || data_out_a !== 8'h01)
                        $display("FAIL b2b_stall: level=%0d req=%b data_out=%h expected %0d/1/01",
                                 level_a, req_a, data_out_a, D);
                    else passed++;
                    resp_start();
                end
                tick();
                k++;
            end
            if (!in_ready_a) begin
                total++;
                $display("FAIL b2b_push_timeout: word %0d never accepted", w);
            end else begin
                exp_q.push_back(8'(w));
                tick();
            end
        end
        in_valid_a = 1'b0;
        total++;
        if (!stalled) $display("FAIL b2b_backpressure: in_ready never held low, stalled=%b expected 1", stalled);
        else passed++;
        if (!resp_en) resp_start();
        k = 0;
        while ((hs_done < 6 || busy_a || ack_a) && k < 400) begin tick(); k++; end
        total++;
        if (hs_done !== 6 || exp_q.size() != 0 || busy_a !== 1'b0)
            $display("FAIL b2b_drain: handshakes=%0d pending=%0d busy=%b expected 6/0/0",
                     hs_done, exp_q.size(), busy_a);
        else passed++;
        resp_en = 1'b0;
    endtask

    task automatic test_stale_ack();
        int k;
        exp_q.delete();
        resp_en = 1'b0;
        rst   = 1'b1;
        ack_a = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();                    // ack_s has settled high
        in_data_a  = 8'h3C;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (req_a !== 1'b0 || level_a !== LW'(1) || data_out_a !== 8'h00)
                $display("FAIL stale_ack_hold cycle %0d: req=%b level=%0d data_out=%h expected 0/1/00",
                         i, req_a, level_a, data_out_a);
            else passed++;
        end
        exp_q.push_back(8'h3C);
        ack_a = 1'b0;
        resp_start();
        repeat (2) tick();                    // ack_s still high through these edges
        total++;
        if (req_a !== 1'b0 || data_out_a !== 8'h00)
            $display("FAIL stale_ack_sync_delay: req=%b data_out=%h expected 0/00", req_a, data_out_a);
        else passed++;
        k = 0;
        while ((hs_done < 1 || busy_a || ack_a) && k < 60) begin tick(); k++; end
        total++;
        if (hs_done !== 1 || exp_q.size() != 0 || busy_a !== 1'b0)
            $display("FAIL stale_ack_handshake: handshakes=%0d pending=%0d busy=%b expected 1/0/0",
                     hs_done, exp_q.size(), busy_a);
        else passed++;
        resp_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        exp_q.delete();
        resp_en = 1'b0;
        ack_a   = 1'b0;
        in_data_a  = 8'h77;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        k = 0;
        while (!req_a && k < 20) begin tick(); k++; end
        total++;
        if (dbg_state_a !== REQ_HI || req_a !== 1'b1)
            $display("FAIL mid_reach_req_hi: state=%0d req=%b expected %0d/1", dbg_state_a, req_a, REQ_HI);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (req_a !== 1'b0 || level_a !== LW'(0) || in_ready_a !== 1'b1 || data_out_a !== 8'h00 || dbg_state_a !== IDLE)
            $display("FAIL mid_async_reset: req=%b level=%0d in_ready=%b data_out=%h state=%0d expected 0/0/1/00/0",
                     req_a, level_a, in_ready_a, data_out_a, dbg_state_a);
        else passed++;
        ack_a = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (req_a !== 1'b0 || busy_a !== 1'b0)
                $display("FAIL mid_ack_high_after_release cycle %0d: req=%b busy=%b expected 0/0", i, req_a, busy_a);
            else passed++;
        end
        ack_a = 1'b0;
        repeat (4) tick();
        total++;
        if (req_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL mid_ack_dropped: req=%b busy=%b expected 0/0", req_a, busy_a);
        else passed++;
        in_data_a  = 8'h5A;
        in_valid_a = 1'b1;
        exp_q.push_back(8'h5A);
        resp_start();
        tick();
        in_valid_a = 1'b0;
        k = 0;
        while ((hs_done < 1 || busy_a || ack_a) && k < 60) begin tick(); k++; end
        total++;
        if (hs_done !== 1 || exp_q.size() != 0 || busy_a !== 1'b0)
            $display("FAIL mid_new_handshake: handshakes=%0d pending=%0d busy=%b expected 1/0/0",
                     hs_done, exp_q.size(), busy_a);
        else passed++;
        resp_en = 1'b0;
    endtask

    task automatic test_setup0();
        int k;
        logic [W-1:0] prev_data;
        logic         prev_req;
        ack_b      = 1'b0;
        in_data_b  = 8'hC3;
        in_valid_b = 1'b1;
        tick();                               // edge N: push
        in_valid_b = 1'b0;
        total++;
        if (req_b !== 1'b0 || level_b !== LW'(1))
            $display("FAIL s0_after_push: req=%b level=%0d expected 0/1", req_b, level_b);
        else passed++;
        tick();                               // edge N+1: data and req together
        total++;
        if (data_out_b !== 8'hC3 || req_b !== 1'b1)
            $display("FAIL s0_req_with_data: data_out=%h req=%b expected c3/1", data_out_b, req_b);
        else passed++;
        repeat (2) tick();
        ack_b = 1'b1;
        k = 0;
        while (req_b && k < 10) begin tick(); k++; end
        total++;
        if (req_b !== 1'b0 || data_out_b !== 8'hC3)
            $display("FAIL s0_req_fall: req=%b data_out=%h expected 0/c3", req_b, data_out_b);
        else passed++;
        ack_b = 1'b0;
        k = 0;
        while (busy_b && k < 10) begin tick(); k++; end
        total++;
        if (busy_b !== 1'b0 || dbg_state_b !== IDLE)
            $display("FAIL s0_idle: busy=%b state=%0d expected 0/0", busy_b, dbg_state_b);
        else passed++;

        // Two queued words: the second loads straight from REQ_LO into REQ_HI.
        in_valid_b = 1'b1;
        in_data_b  = 8'h11;
        tick();
        in_data_b  = 8'h22;
        tick();
        in_valid_b = 1'b0;
        k = 0;
        while (!req_b && k < 10) begin tick(); k++; end
        total++;
        if (req_b !== 1'b1 || data_out_b !== 8'h11)
            $display("FAIL s0_first_word: req=%b data_out=%h expected 1/11", req_b, data_out_b);
        else passed++;
        ack_b = 1'b1;
        k = 0;
        while (req_b && k < 10) begin tick(); k++; end
        ack_b = 1'b0;
        prev_data = data_out_b;
        prev_req  = req_b;
        k = 0;
        while (!req_b && k < 10) begin
            prev_data = data_out_b;
            prev_req  = req_b;
            tick();
            k++;
        end
        total++;
        if (req_b !== 1'b1 || data_out_b !== 8'h22 || prev_data !== 8'h11 || prev_req !== 1'b0)
            $display("FAIL s0_second_word: req=%b data_out=%h before=%h/%b expected 1/22 before 11/0",
                     req_b, data_out_b, prev_data, prev_req);
        else passed++;
        ack_b = 1'b1;
        k = 0;
        while (req_b && k < 10) begin tick(); k++; end
        ack_b = 1'b0;
        k = 0;
        while (busy_b && k < 10) begin tick(); k++; end
        total++;
        if (busy_b !== 1'b0 || level_b !== LW'(0))
            $display("FAIL s0_drain: busy=%b level=%0d expected 0/0", busy_b, level_b);
        else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        in_data_a  = '0;
        in_valid_a = 1'b0;
        ack_a      = 1'b0;
        in_data_b  = '0;
        in_valid_b = 1'b0;
        ack_b      = 1'b0;
        resp_en    = 1'b0;
        in_hs      = 1'b0;
        hi_cnt     = 0;
        lo_cnt     = 0;
        hs_done    = 0;
        cur_word   = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_stale_ack();
        test_reset_mid();
        test_setup0();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
